// File: rtl/iob_sync_fifo.sv
// Single-clock FIFO with standard/FWFT read, programmable thresholds,
// sticky overflow/underflow flags and synchronous flush.
module iob_sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_LVL  = 12,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     write_en,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     read_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] L_DEPTH =
    (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] L_AF =
    (ADDRESS_WIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDRESS_WIDTH:0] L_AE =
    (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LVL);

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_wptr;
  logic [ADDRESS_WIDTH-1:0] r_rptr;
  logic [ADDRESS_WIDTH:0]   r_level;
  logic                     r_ovf;
  logic                     r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_level == L_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_wr    = write_en && !w_full && !flush;
  assign w_rd    = read_en && !w_empty && !flush;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= L_AF);
  assign almost_empty = (r_level <= L_AE);
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= data_in;
  end

  // Pointers, level and sticky error flags; flush wins over traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd) r_level <= r_level + 1'b1;
      if (w_rd && !w_wr) r_level <= r_level - 1'b1;
      if (write_en && w_full) r_ovf <= 1'b1;
      if (read_en && w_empty) r_udf <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; zero while nothing is stored.
    always_comb begin
      data_out = '0;
      if (!w_empty) data_out = r_mem[r_rptr];
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;

    // Output register loads the head word on each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_dout <= '0;
      else if (w_rd) r_dout <= r_mem[r_rptr];
    end

    assign data_out = r_dout;
  end

endmodule

// File: tb/tb_iob_sync_fifo.sv
// Randomised and directed bench for iob_sync_fifo, standard and FWFT
// instances driven in parallel against a queue-based reference.
module tb_iob_sync_fifo;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int DEP = 16;
  localparam int AFL = 12;
  localparam int AEL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;

  logic          full, almost_full, empty, almost_empty;
  logic [DW-1:0] data_out;
  logic [AW:0]   level;
  logic          overflow, underflow;

  logic          f_full, f_almost_full, f_empty, f_almost_empty;
  logic [DW-1:0] f_data_out;
  logic [AW:0]   f_level;
  logic          f_overflow, f_underflow;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] m_q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  iob_sync_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(0),
    .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in(data_in), .write_en(write_en),
    .full(full), .almost_full(almost_full),
    .read_en(read_en), .data_out(data_out),
    .empty(empty), .almost_empty(almost_empty),
    .level(level), .overflow(overflow),
    .underflow(underflow)
  );

  iob_sync_fifo #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1),
    .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in(data_in), .write_en(write_en),
    .full(f_full), .almost_full(f_almost_full),
    .read_en(read_en), .data_out(f_data_out),
    .empty(f_empty), .almost_empty(f_almost_empty),
    .level(f_level), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Reference behaviour of one clock edge, using pre-edge inputs.
  task automatic model_edge();
    bit was_full, was_empty;
    if (!rst_n) return;
    if (flush) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    was_full  = (m_q.size() == DEP);
    was_empty = (m_q.size() == 0);
    if (write_en && was_full) m_ovf = 1'b1;
    if (read_en && was_empty) m_udf = 1'b1;
    if (read_en && !was_empty) m_dout = m_q.pop_front();
    if (write_en && !was_full) m_q.push_back(data_in);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int sz;
      sz = m_q.size();
      chk("level", int'(level), sz);
      chk("full", int'(full), int'(sz == DEP));
      chk("almost_full", int'(almost_full), int'(sz >= AFL));
      chk("empty", int'(empty), int'(sz == 0));
      chk("almost_empty", int'(almost_empty), int'(sz <= AEL));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
      chk("data_out", int'(data_out), int'(m_dout));
      chk("f_level", int'(f_level), sz);
      chk("f_empty", int'(f_empty), int'(sz == 0));
      chk("f_overflow", int'(f_overflow), int'(m_ovf));
      chk("f_underflow", int'(f_underflow), int'(m_udf));
      if (sz > 0) chk("f_data_out", int'(f_data_out), int'(m_q[0]));
    end
  end

  initial begin
    // 1. reset, async assertion mid-burst
    model_reset();
    #23;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_dout", int'(data_out), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      data_in = DW'(8'h50 + i);
      write_en = 1'b1;
      step();
    end
    chk("pre_rst_level", int'(level), 6);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_level", int'(level), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_aempty", int'(almost_empty), 1);
    chk("async_full", int'(full), 0);
    chk("async_afull", int'(almost_full), 0);
    chk("async_dout", int'(data_out), 0);
    chk("async_ovf", int'(overflow), 0);
    chk("async_udf", int'(underflow), 0);
    idle();
    #3;
    rst_n = 1'b1;
    data_in = 8'h11;
    write_en = 1'b1;
    step();
    chk("first_write_level", int'(level), 1);
    idle();
    read_en = 1'b1;
    step();
    chk("first_read_dout", int'(data_out), 8'h11);
    idle();

    // 2. fill
    for (int i = 0; i < 16; i++) begin
      data_in = DW'(i);
      write_en = 1'b1;
      step();
      chk("fill_level", int'(level), i + 1);
      if (i == 10) chk("afull_at11", int'(almost_full), 0);
      if (i == 11) chk("afull_at12", int'(almost_full), 1);
      if (i == 14) chk("full_at15", int'(full), 0);
    end
    chk("full_at16", int'(full), 1);
    data_in = 8'hAA;
    step();
    chk("ovf_level", int'(level), 16);
    chk("ovf_flag", int'(overflow), 1);
    idle();

    // 3. drain in standard mode
    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      step();
      chk("drain_dout", int'(data_out), i);
      if (i == 13) chk("aempty_at2", int'(almost_empty), 1);
      if (i == 12) chk("aempty_at3", int'(almost_empty), 0);
    end
    chk("drain_empty", int'(empty), 1);
    step();
    chk("udf_flag", int'(underflow), 1);
    chk("udf_dout_hold", int'(data_out), 15);
    idle();

    // 4. wrap with simultaneous traffic
    flush = 1'b1;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(100 + i);
      write_en = 1'b1;
      step();
    end
    for (int i = 0; i < 20; i++) begin
      data_in = DW'(105 + i);
      write_en = 1'b1;
      read_en = 1'b1;
      step();
      chk("wrap_level", int'(level), 5);
      chk("wrap_dout", int'(data_out), 100 + i);
    end
    read_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      data_in = DW'(200 + i);
      step();
    end
    chk("wrap_full", int'(full), 1);
    read_en = 1'b1;
    data_in = 8'hEE;
    step();
    chk("both_full_level", int'(level), 15);
    chk("both_full_ovf", int'(overflow), 1);
    chk("both_full_dout", int'(data_out), 120);
    idle();

    // 5. FWFT instance
    flush = 1'b1;
    step();
    idle();
    data_in = 8'h3C;
    write_en = 1'b1;
    step();
    idle();
    chk("fwft_empty", int'(f_empty), 0);
    chk("fwft_dout", int'(f_data_out), 8'h3C);
    read_en = 1'b1;
    step();
    idle();
    chk("fwft_rd_empty", int'(f_empty), 1);
    chk("fwft_rd_level", int'(f_level), 0);

    // 6. flush with concurrent write
    for (int i = 0; i < 17; i++) begin
      data_in = DW'(i + 1);
      write_en = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 7; i++) begin
      read_en = 1'b1;
      step();
    end
    idle();
    chk("pre_flush_level", int'(level), 9);
    chk("pre_flush_ovf", int'(overflow), 1);
    flush = 1'b1;
    write_en = 1'b1;
    data_in = 8'hEE;
    step();
    idle();
    chk("flush_level", int'(level), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovf", int'(overflow), 0);
    for (int i = 0; i < 2; i++) begin
      data_in = DW'(8'h71 + i);
      write_en = 1'b1;
      step();
    end
    idle();
    read_en = 1'b1;
    step();
    chk("post_flush_rd0", int'(data_out), 8'h71);
    step();
    chk("post_flush_rd1", int'(data_out), 8'h72);
    idle();

    // 7. randomised traffic with shifting bias
    for (int i = 0; i < 1500; i++) begin
      int wb, rb;
      wb = (i / 150) % 2 == 0 ? 75 : 35;
      rb = 110 - wb;
      write_en = ($urandom_range(99) < wb);
      read_en  = ($urandom_range(99) < rb);
      flush    = ($urandom_range(199) == 0);
      data_in  = DW'($urandom);
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
